// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
//
// Front-panel time-setting controller for the range-hood clock. It converts
// debounced panel buttons into a field-select code and a load value for the
// clock/work-time block. Pressing mode walks hour -> minute -> second -> hour.
// Up/down step the selected field with wrap-around, and holding a button
// auto-repeats. Setting mode is left on ok, on power-off, or after an idle
// timeout.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   tick          in   one-clk 100 Hz enable; every timer advances only on tick
//   power_on      in   hood power state; low forces exit from setting mode
//   btn_mode      in   pulse: enter setting mode / advance to next field
//   btn_ok        in   pulse: confirm and exit
//   btn_up        in   debounced level: increment
//   btn_down      in   debounced level: decrement
//   cur_hour      in   [5:0] current hour from the clock block
//   cur_minute    in   [5:0] current minute from the clock block
//   cur_second    in   [5:0] current second from the clock block
//   set_all_times out  [1:0] field select: 00 run, 01 sec, 10 min, 11 hour
//   btn_time_set  out  [5:0] value loaded into the selected field
//   setting       out  high while any field is being edited
//   blink         out  display blink flag for the selected field
// -----------------------------------------------------------------------------
module time_set_ctrl #(
    parameter int TIMEOUT_TICKS = 1000,
    parameter int HOLD_TICKS    = 50,
    parameter int REPEAT_TICKS  = 10,
    parameter int BLINK_TICKS   = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       power_on,
    input  logic       btn_mode,
    input  logic       btn_ok,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_minute,
    input  logic [5:0] cur_second,
    output logic [1:0] set_all_times,
    output logic [5:0] btn_time_set,
    output logic       setting,
    output logic       blink
);

    localparam int TO_W   = $clog2(TIMEOUT_TICKS + 1);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam int BL_W   = $clog2(BLINK_TICKS + 1);

    // The state encoding is the field-select code, so the state register
    // drives set_all_times directly.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SET_SEC  = 2'b01,
        SET_MIN  = 2'b10,
        SET_HOUR = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [5:0]          val_q, val_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [BL_W-1:0]     bl_q, bl_d;
    logic                blink_q, blink_d;
    logic                setting_q, setting_d;
    logic                up_prev_q, dn_prev_q;

    logic                up_rise, dn_rise, activity;
    logic                fire, timeout;
    logic [TO_W-1:0]     to_inc;
    logic [HOLD_W-1:0]   hold_inc;
    logic [BL_W-1:0]     bl_inc;
    logic [5:0]          field_max;

    // Wrap-around step within [0, vmax]; out-of-range inputs snap into range.
    function automatic logic [5:0] step_val(input logic [5:0] v,
                                            input logic       up,
                                            input logic [5:0] vmax);
        if (up) begin
            return (v >= vmax) ? 6'd0 : v + 6'd1;
        end
        return (v == 6'd0 || v > vmax) ? vmax : v - 6'd1;
    endfunction

    function automatic state_t next_field(input state_t s);
        case (s)
            SET_HOUR: return SET_MIN;
            SET_MIN:  return SET_SEC;
            default:  return SET_HOUR;
        endcase
    endfunction

    assign up_rise   = btn_up & ~up_prev_q;
    assign dn_rise   = btn_down & ~dn_prev_q;
    assign activity  = btn_mode | btn_ok | up_rise | dn_rise;
    assign to_inc    = to_q + TO_W'(1);
    assign hold_inc  = hold_q + HOLD_W'(1);
    assign bl_inc    = bl_q + BL_W'(1);
    assign timeout   = tick & ~activity & (to_inc == TO_W'(TIMEOUT_TICKS));
    assign field_max = (state_q == SET_HOUR) ? 6'd23 : 6'd59;

    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        to_d      = to_q;
        hold_d    = hold_q;
        bl_d      = bl_q;
        blink_d   = blink_q;
        fire      = 1'b0;

        // Hold / auto-repeat: a press steps immediately; a held button steps
        // after HOLD_TICKS, then the counter is rewound so the next step lands
        // REPEAT_TICKS later.
        if (btn_up && btn_down) begin
            hold_d = '0;
        end else if (btn_up || btn_down) begin
            if (btn_up ? up_rise : dn_rise) begin
                fire   = 1'b1;
                hold_d = '0;
            end else if (tick) begin
                if (hold_inc == HOLD_W'(HOLD_TICKS)) begin
                    fire   = 1'b1;
                    hold_d = HOLD_W'(HOLD_TICKS - REPEAT_TICKS);
                end else begin
                    hold_d = hold_inc;
                end
            end
        end else begin
            hold_d = '0;
        end

        if (activity) begin
            to_d = '0;
        end else if (tick) begin
            to_d = to_inc;
        end

        if (tick) begin
            if (bl_inc == BL_W'(BLINK_TICKS)) begin
                bl_d    = '0;
                blink_d = ~blink_q;
            end else begin
                bl_d = bl_inc;
            end
        end

        if (state_q == IDLE) begin
            val_d   = '0;
            to_d    = '0;
            hold_d  = '0;
            bl_d    = '0;
            blink_d = 1'b0;
            if (btn_mode && power_on) begin
                state_d = SET_HOUR;
                val_d   = cur_hour;
                blink_d = 1'b1;
            end
        end else if (!power_on || btn_ok || timeout) begin
            state_d = IDLE;
            val_d   = '0;
            to_d    = '0;
            hold_d  = '0;
            bl_d    = '0;
            blink_d = 1'b0;
        end else if (btn_mode) begin
            // Field entry loads the live value together with the new select.
            state_d = next_field(state_q);
            case (next_field(state_q))
                SET_HOUR: val_d = cur_hour;
                SET_MIN:  val_d = cur_minute;
                default:  val_d = cur_second;
            endcase
            to_d    = '0;
            hold_d  = '0;
            bl_d    = '0;
            blink_d = 1'b1;
        end else if (fire) begin
            val_d   = step_val(val_q, btn_up, field_max);
            bl_d    = '0;
            blink_d = 1'b1;
        end

        setting_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            val_q     <= '0;
            to_q      <= '0;
            hold_q    <= '0;
            bl_q      <= '0;
            blink_q   <= 1'b0;
            setting_q <= 1'b0;
            up_prev_q <= 1'b0;
            dn_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            val_q     <= val_d;
            to_q      <= to_d;
            hold_q    <= hold_d;
            bl_q      <= bl_d;
            blink_q   <= blink_d;
            setting_q <= setting_d;
            up_prev_q <= btn_up;
            dn_prev_q <= btn_down;
        end
    end

    assign set_all_times = state_q;
    assign btn_time_set  = val_q;
    assign setting       = setting_q;
    assign blink         = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       reset, tick, power_on, btn_mode, btn_ok, btn_up, btn_down;
    logic [5:0] cur_hour, cur_minute, cur_second;
    logic [1:0] set_all_times;
    logic [5:0] btn_time_set;
    logic       setting, blink;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    time_set_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .power_on      (power_on),
        .btn_mode      (btn_mode),
        .btn_ok        (btn_ok),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .cur_hour      (cur_hour),
        .cur_minute    (cur_minute),
        .cur_second    (cur_second),
        .set_all_times (set_all_times),
        .btn_time_set  (btn_time_set),
        .setting       (setting),
        .blink         (blink)
    );

    typedef struct {
        logic       mode, ok, up, dn, pwr;
        logic [5:0] h, m, s;
        logic [1:0] esel;
        logic [5:0] eval;
        logic       eset, eblk;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic mode, logic ok, logic up, logic dn, logic pwr,
                                int h, int m, int s, int esel, int eval, logic eset, logic eblk);
        vec_t v;
        v.mode = mode; v.ok = ok; v.up = up; v.dn = dn; v.pwr = pwr;
        v.h = 6'(h); v.m = 6'(m); v.s = 6'(s);
        v.esel = 2'(esel); v.eval = 6'(eval); v.eset = eset; v.eblk = eblk;
        return v;
    endfunction

    // One clock; inputs set before the call are sampled at that edge and the
    // outputs are read 1 ns after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tk(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; cyc();
            tick = 1'b0; cyc();
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int sel, input int val, input int set, input int blk);
        chk({name, ".sel"},   int'(set_all_times), sel);
        chk({name, ".val"},   int'(btn_time_set),  val);
        chk({name, ".set"},   int'(setting),       set);
        chk({name, ".blink"}, int'(blink),         blk);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; power_on = 1'b1;
        btn_mode = 1'b0; btn_ok = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        cur_hour = 6'd14; cur_minute = 6'd0; cur_second = 6'd0;
        cyc(); cyc();
        chk_all("reset", 0, 0, 0, 0);
        reset = 1'b0;

        //           mode ok up dn pwr  h  m  s   sel val set blk
        tbl.push_back(mk(0, 0, 0, 0, 1, 14, 0, 0,  0,  0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 14, 0, 0,  3, 14, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 14, 0, 0,  3, 14, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 14, 0, 0,  0,  0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 23, 0, 0,  3, 23, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 23, 0, 0,  3,  0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 23, 0, 0,  3,  0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 23, 0, 0,  3, 23, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 23, 0, 0,  3, 23, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 23, 0, 0,  2,  0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 23, 0, 0,  2, 59, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 23, 0, 0,  2, 59, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 23, 0, 0,  0,  0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1,  8, 30, 45, 3,  8, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1,  8, 30, 45, 2, 30, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1,  8, 30, 45, 1, 45, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1,  8, 30, 45, 3,  8, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1,  8, 30, 45, 0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1,  8, 30, 45, 0,  0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0,  8, 30, 45, 0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,  8, 30, 45, 0,  0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1,  5, 30, 45, 3,  5, 1, 1));
        tbl.push_back(mk(1, 1, 0, 0, 1,  5, 30, 45, 0,  0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1,  5, 30, 45, 3,  5, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 1,  5, 30, 45, 3,  5, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1,  5, 30, 45, 3,  5, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1,  5, 30, 45, 3,  5, 1, 1));
        tbl.push_back(mk(1, 0, 1, 0, 1,  5, 30, 45, 2, 30, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1,  5, 30, 45, 2, 30, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1,  5, 30, 45, 0,  0, 0, 0));

        foreach (tbl[i]) begin
            btn_mode = tbl[i].mode; btn_ok = tbl[i].ok;
            btn_up = tbl[i].up; btn_down = tbl[i].dn; power_on = tbl[i].pwr;
            cur_hour = tbl[i].h; cur_minute = tbl[i].m; cur_second = tbl[i].s;
            cyc();
            chk_all($sformatf("vec%0d", i), int'(tbl[i].esel), int'(tbl[i].eval),
                    int'(tbl[i].eset), int'(tbl[i].eblk));
        end
        btn_mode = 1'b0; btn_ok = 1'b0; btn_up = 1'b0; btn_down = 1'b0; power_on = 1'b1;

        // Hold-to-repeat in SET_MIN starting at 10.
        cur_hour = 6'd8; cur_minute = 6'd10; cur_second = 6'd45;
        btn_mode = 1'b1; cyc(); cyc(); btn_mode = 1'b0;
        chk("rep.sel", int'(set_all_times), 2);
        chk("rep.start", int'(btn_time_set), 10);
        btn_up = 1'b1; cyc();
        chk("rep.press", int'(btn_time_set), 11);
        for (int n = 1; n <= 80; n++) begin
            tk(1);
            chk($sformatf("rep.t%0d", n), int'(btn_time_set),
                11 + int'(n >= 50) + int'(n >= 60) + int'(n >= 70) + int'(n >= 80));
        end
        btn_up = 1'b0; cyc(); tk(15);
        chk("rep.released", int'(btn_time_set), 15);
        chk("rep.still_set", int'(set_all_times), 2);

        // Blink period and timeout in SET_SEC.
        btn_ok = 1'b1; cyc(); btn_ok = 1'b0;
        btn_mode = 1'b1; cyc(); cyc(); cyc(); btn_mode = 1'b0;
        chk_all("sec.entry", 1, 45, 1, 1);
        tk(49);  chk("blink.t49", int'(blink), 1);
        tk(1);   chk("blink.t50", int'(blink), 0);
        tk(50);  chk("blink.t100", int'(blink), 1);
        tk(899); chk("to.t999", int'(setting), 1);
        tk(1);   chk_all("to.t1000", 0, 0, 0, 0);

        // Activity on the 999th tick restarts the count.
        btn_mode = 1'b1; cyc(); cyc(); cyc(); btn_mode = 1'b0;
        chk("to2.sel", int'(set_all_times), 1);
        tk(998);
        btn_up = 1'b1; tk(1); btn_up = 1'b0;
        chk("to2.t999.set", int'(setting), 1);
        chk("to2.t999.val", int'(btn_time_set), 46);
        tk(999); chk("to2.restart999", int'(setting), 1);
        tk(1);   chk_all("to2.restart1000", 0, 0, 0, 0);

        // Power drop with a coinciding up edge: exit, no step.
        cur_hour = 6'd5;
        btn_mode = 1'b1; cyc(); btn_mode = 1'b0;
        chk("pwr.entry", int'(btn_time_set), 5);
        power_on = 1'b0; btn_up = 1'b1; cyc();
        chk_all("pwr.drop", 0, 0, 0, 0);
        power_on = 1'b1; btn_up = 1'b0; cyc();

        // Reset in the middle of auto-repeat.
        btn_mode = 1'b1; cyc(); btn_mode = 1'b0;
        btn_up = 1'b1; cyc(); tk(55);
        chk("rst.before", int'(btn_time_set), 7);
        reset = 1'b1; cyc();
        chk_all("rst.mid", 0, 0, 0, 0);
        reset = 1'b0; tk(5);
        chk_all("rst.after", 0, 0, 0, 0);
        btn_up = 1'b0; cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
